nec_ir_tx: RTL

//  NEC-protocol infrared transmitter: the sending end of the link decoded by irReceiver.

---
 rtl/nec_ir_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: serialises a 32-bit word (or a repeat code) into the
// NEC mark/space envelope and gates it with a square-wave carrier for the IR LED.
module nec_ir_tx #(
    parameter int TICK_DIV    = 28125,
    parameter int CARRIER_DIV = 658,
    parameter int GAP_UNITS   = 72
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        repeat_code,
    input  logic [31:0] word,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_out
);

    localparam int UCW  = $clog2(TICK_DIV);
    localparam int CCW  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int MAXU = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int DW   = $clog2(MAXU + 1);
    localparam logic [UCW-1:0] UNIT_LAST = UCW'(TICK_DIV - 1);
    localparam logic [CCW-1:0] CAR_LAST  = CCW'(CARRIER_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;

    state_t         state, state_nxt;
    logic [UCW-1:0] unit_cnt, unit_nxt;
    logic [DW-1:0]  idx, idx_nxt;
    logic [4:0]     bit_cnt, bit_nxt;
    logic [31:0]    shreg, sh_nxt;
    logic           rpt, rpt_nxt;
    logic [CCW-1:0] car_cnt, car_cnt_nxt;
    logic           car_ph, car_ph_nxt;
    logic           unit_tick, last_unit, done_nxt;

    // Length of a state in NEC units; bit spaces depend on the bit being sent.
    function automatic logic [DW-1:0] units_of(state_t s, logic r, logic b);
        case (s)
            LEAD_MARK:  return DW'(16);
            LEAD_SPACE: return r ? DW'(4) : DW'(8);
            BIT_SPACE:  return b ? DW'(3) : DW'(1);
            GAP:        return DW'(GAP_UNITS);
            default:    return DW'(1);
        endcase
    endfunction

    function automatic logic is_mark(state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    function automatic logic is_final(state_t s);
        return (s == GAP) || ((s == STOP_MARK) && (GAP_UNITS == 0));
    endfunction

    always_comb begin
        state_nxt   = state;
        unit_nxt    = unit_cnt;
        idx_nxt     = idx;
        bit_nxt     = bit_cnt;
        sh_nxt      = shreg;
        rpt_nxt     = rpt;
        car_cnt_nxt = '0;
        car_ph_nxt  = 1'b0;
        unit_tick   = (unit_cnt == UNIT_LAST);
        last_unit   = unit_tick && (idx == units_of(state, rpt, shreg[31]) - 1'b1);

        if (state == IDLE) begin
            unit_nxt = '0;
            idx_nxt  = '0;
            bit_nxt  = '0;
            if (start) begin
                state_nxt = LEAD_MARK;
                sh_nxt    = word;
                rpt_nxt   = repeat_code;
            end
        end else begin
            unit_nxt = unit_tick ? '0 : unit_cnt + 1'b1;
            if (unit_tick)
                idx_nxt = idx + 1'b1;
            if (last_unit) begin
                idx_nxt = '0;
                case (state)
                    LEAD_MARK:  state_nxt = LEAD_SPACE;
                    LEAD_SPACE: state_nxt = rpt ? STOP_MARK : BIT_MARK;
                    BIT_MARK:   state_nxt = BIT_SPACE;
                    BIT_SPACE: begin
                        sh_nxt    = {shreg[30:0], 1'b0};
                        bit_nxt   = bit_cnt + 1'b1;
                        state_nxt = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
                    end
                    STOP_MARK:  state_nxt = (GAP_UNITS > 0) ? GAP : IDLE;
                    default:    state_nxt = IDLE;
                endcase
            end
        end

        // Every mark is entered from a different state, so entry restarts the carrier high.
        if (is_mark(state_nxt) && (state_nxt != state)) begin
            car_ph_nxt = 1'b1;
        end else if (is_mark(state_nxt)) begin
            car_cnt_nxt = (car_cnt == CAR_LAST) ? '0 : car_cnt + 1'b1;
            car_ph_nxt  = (car_cnt == CAR_LAST) ? ~car_ph : car_ph;
        end

        // Registered done: flag the coming cycle if it is the last cycle of the frame.
        done_nxt = is_final(state_nxt) && (unit_nxt == UNIT_LAST) &&
                   (idx_nxt == units_of(state_nxt, rpt_nxt, sh_nxt[31]) - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            unit_cnt <= '0;
            idx      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rpt      <= 1'b0;
            car_cnt  <= '0;
            car_ph   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ir_env   <= 1'b0;
            ir_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            unit_cnt <= unit_nxt;
            idx      <= idx_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= sh_nxt;
            rpt      <= rpt_nxt;
            car_cnt  <= car_cnt_nxt;
            car_ph   <= car_ph_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            ir_env   <= is_mark(state_nxt);
            ir_out   <= is_mark(state_nxt) & car_ph_nxt;
        end
    end

endmodule
